// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event queue.
// Provides default sizing, the button code constants and the code-width helper.
package btn_evt_pkg;

    localparam int unsigned N_BTN_DEF = 5;
    localparam int unsigned DEPTH_DEF = 4;

    // Button codes as emitted on evt_code
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_L = 3;
    localparam int unsigned BTN_R = 4;

    // Width of a button code; a single button still needs one bit
    function automatic int unsigned cw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_event_queue_if.sv
// Event-queue bus: press ticks in, ordered button codes out.
//   tick_in   : one-cycle press pulses, one bit per button
//   evt_ready : consumer accepts the head event
//   evt_valid : head event available
//   evt_code  : button index of the head event
//   evt_count : current queue occupancy
//   overflow  : sticky dropped-press flag
//   ovf_clr   : clears overflow
interface btn_evt_if
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN = N_BTN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned CW = cw(N_BTN);
    localparam int unsigned NW = $clog2(DEPTH) + 1;

    logic [N_BTN-1:0] tick_in;
    logic             evt_ready;
    logic             ovf_clr;
    logic             evt_valid;
    logic [CW-1:0]    evt_code;
    logic [NW-1:0]    evt_count;
    logic             overflow;

    // Driver side: detectors and consumer
    modport master (
        output tick_in, evt_ready, ovf_clr,
        input  evt_valid, evt_code, evt_count, overflow
    );

    // Queue side
    modport slave (
        input  tick_in, evt_ready, ovf_clr,
        output evt_valid, evt_code, evt_count, overflow
    );
endinterface

// File: rtl/btn_event_queue_evt_fifo.sv
// First-word-fall-through circular buffer for button codes.
//   clk, rst      : clock, async active-high reset
//   push_i/data_i : write request and data (honoured when not full or popping)
//   pop_i         : read request (ignored when empty)
//   full_o/empty_o: occupancy flags
//   count_o       : registered occupancy
//   head_o        : head entry, zero when empty
module evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DW-1:0]              head_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry a wrap bit: equal means empty, only-MSB-differs means full
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + PW'(push_ok) - PW'(pop_ok);
        head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        count_o  = count_q;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never exposed while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/btn_event_queue.sv
// Button event queue: latches press ticks in a pending register, grants the
// lowest pending button into a FWFT queue each cycle, and flags dropped presses.
//   clk, rst : clock, async active-high reset
//   bus      : btn_evt_if slave (ticks in, valid/ready code stream out)
module btn_event_queue
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN = N_BTN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    btn_evt_if.slave bus
);
    localparam int unsigned CW = cw(N_BTN);

    logic [N_BTN-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic [N_BTN-1:0] grant_c;
    logic [CW-1:0]    push_code;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_head;

    // Lowest-index grant, allowed when the queue has room or frees a slot now
    always_comb begin
        pop       = ~fifo_empty & bus.evt_ready;
        grant_c   = '0;
        if (~fifo_full | pop) begin
            grant_c = pend_q & (~pend_q + N_BTN'(1));
        end
        push      = |grant_c;
        push_code = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (grant_c[i]) begin
                push_code = CW'(i);
            end
        end
        // A repeat on a bit still waiting for a slot is lost
        drop   = |(bus.tick_in & pend_q & ~grant_c);
        pend_d = (pend_q & ~grant_c) | bus.tick_in;
        ovf_d  = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Pending presses and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .DW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_code),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.evt_count),
        .head_o  (fifo_head)
    );

    assign bus.evt_valid = ~fifo_empty;
    assign bus.evt_code  = fifo_head;
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/btn_event_queue.md
# btn_event_queue

Collects single-cycle press ticks from up to `N_BTN` push-button detector instances and turns them into an ordered stream of button codes with a valid/ready handshake. It sits directly downstream of the per-button push detectors and upstream of the control FSM. Simultaneous or back-to-back presses are captured without loss. Each button can hold at most one outstanding press while the queue is full; further presses on that button are dropped and flagged.

## Interface
Parameters:
- `N_BTN`, 5: number of tick inputs (1..8).
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `tick_in`  in  N_BTN  one-cycle press pulses, one bit per button.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_valid`  out  1  head event available.
- `evt_code`  out  CW=$clog2(N_BTN)  button index of the head event.
- `evt_count`  out  $clog2(DEPTH)+1  current queue occupancy.
- `overflow`  out  1  sticky flag: a press was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- The pending register `P[N_BTN]` latches ticks.
  - `P_next = (P & ~grant) | tick_in`.
- `grant` is one-hot: the lowest set bit of `P`.
  - It is nonzero only when `P != 0` and (queue not full, or a pop occurs this cycle).
- On a grant, the granted index is pushed into the queue.
- Pop occurs when `evt_valid & evt_ready`. `evt_ready` is ignored when `evt_valid = 0`.
- The queue is a circular buffer. Read/write pointers carry an extra wrap bit.
  - full = MSBs differ, LSBs equal.
  - empty = pointers equal.
- `evt_valid = !empty`. `evt_code = mem[rd_ptr]` when valid, else 0.
- Head data is first-word-fall-through. `evt_code` is stable while `evt_valid = 1` and no pop occurs.
- Boundary rules:
  - **Push + pop, queue full:** both happen; count unchanged.
  - **Push + pop, queue empty:** no bypass. The pushed entry becomes valid the next cycle.
  - **Tick on a bit that is pending and not granted this cycle:** the press is dropped and `overflow` is set.
  - **Tick on a bit being granted this cycle:** the bit stays pending; no overflow.
  - **Queue full, no pop:** presses accumulate in `P`, at most one per button. There is no loss until a repeat on the same bit.
  - **`overflow` set and `ovf_clr` in the same cycle:** set wins.
- Reset, including mid-operation, immediately forces:
  - `P = 0`, both pointers = 0;
  - `evt_valid = 0`, `evt_code = 0`, `evt_count = 0`, `overflow = 0`.
  - Queue memory contents need not be reset; they are never exposed while empty.

## Timing
- All state is updated on `posedge clk` or cleared on `posedge rst`.
- Latency, empty queue, no contention: tick high in cycle 0 → `P` bit set after edge 1 → push at edge 2 → `evt_valid` high in cycle 2.
- Throughput: one push and one pop per cycle.
- N simultaneous ticks drain into the queue over N consecutive cycles, lowest index first.
- `evt_count` and `overflow` are registered and reflect state after the last edge.

## Structure
- Package `btn_evt_pkg`:
  - default `N_BTN`, `DEPTH`;
  - code constants `BTN_C=0`, `BTN_U=1`, `BTN_D=2`, `BTN_L=3`, `BTN_R=4`;
  - a `CW` width function.
- Sub-module `evt_fifo`: synchronous FWFT circular buffer with `push`/`pop`/`full`/`empty`/`count`.
- Top level contains the pending register, lowest-bit priority grant, and overflow flag.

## Test plan
- **Single tick:** `tick_in = 5'b00100` in cycle 0, `evt_ready = 1` → `evt_valid = 1`, `evt_code = 2` for cycle 2 only; `evt_count` returns to 0; `overflow = 0`.
- **Simultaneous ticks:** `tick_in = 5'b11010` in one cycle, `evt_ready = 1` → codes 1, 3, 4 in cycles 2, 3, 4; no gaps.
- **Fill and drain:** `evt_ready = 0`; single ticks on bits 0, 1, 2, 3, 4 in separate cycles.
  - Expect `evt_count = 4` and `P = 5'b10000`.
  - Then `evt_ready = 1` → codes 0, 1, 2, 3, 4 in order; `overflow = 0`.
- **Overflow:** queue full, `evt_ready = 0`; tick bit 0 twice, 3 cycles apart → `overflow = 1` and stays 1. `ovf_clr` pulse → `overflow = 0` next cycle. `ovf_clr` coincident with a new drop → stays 1.
- **Push/pop on full:** queue full with bit 2 pending; `evt_ready = 1` for one cycle → one code popped and code 2 pushed in the same cycle; `evt_count` stays 4.
- **Reset mid-stream:** `rst` asserted mid-cycle with `evt_count = 3` and `P != 0` → `evt_valid`, `evt_count`, `overflow` go to 0 without waiting for a clock edge. After release, no stale events appear; a fresh tick on bit 4 yields code 4 two cycles later.
